uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of the UART receiver, in the baud-clock domain.
- Captures each completed byte, flagged by the receiver's done output, into a circular FIFO.
- Presents the buffered bytes to the host through a read-enable interface.
- Decouples host read latency from line rate; drops and flags bytes on overflow.

---
 rtl/uart_rx_fifo.sv | 73 +++++++
 tb/tb_uart_rx_fifo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver, baud-clock domain.
// Edge-detects rx_done, buffers bytes, serves the host with 1-cycle reads.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              done_q;
  logic              wr_req;
  logic              rd_ok;
  logic              wr_ok;
  logic              drop;

  assign wr_req = rx_done & ~done_q;
  assign rd_ok  = rd_en & ~empty;
  // a read in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_ok  = wr_req & (~full | rd_ok);
  assign drop   = wr_req & full & ~rd_ok;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done_q   <= rx_done;
      rd_valid <= rd_ok;
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ADDR_W'(1);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo.
// Expected values are hand-derived constants and loop indices.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       clr_ovf;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk(tag, {31'd0, rd_valid}, 32'd1);
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    reset   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    rd_en   = 1'b0;
    clr_ovf = 1'b0;
    tick();
    tick();
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_rdv", {31'd0, rd_valid}, 32'd0);
    chk("rst_rdd", {24'd0, rd_data}, 32'd0);
    reset = 1'b1;
    tick();

    // single byte in, single byte out
    wr(8'hA5);
    chk("t1_count", {27'd0, count}, 32'd1);
    chk("t1_empty", {31'd0, empty}, 32'd0);
    rd("t1_rd", 8'hA5);
    chk("t1_empty2", {31'd0, empty}, 32'd1);
    tick();
    chk("t1_rdv_drop", {31'd0, rd_valid}, 32'd0);

    // held rx_done writes once
    rx_data = 8'h3C;
    rx_done = 1'b1;
    repeat (5) tick();
    rx_done = 1'b0;
    tick();
    chk("t2_count", {27'd0, count}, 32'd1);
    rd("t2_rd", 8'h3C);

    // fill, overflow, drain
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("t3_full", {31'd0, full}, 32'd1);
    chk("t3_count", {27'd0, count}, 32'd16);
    wr(8'hFF);
    chk("t3_ovf", {31'd0, overflow}, 32'd1);
    chk("t3_count2", {27'd0, count}, 32'd16);
    clr_ovf = 1'b1;
    tick();
    chk("t3_clr", {31'd0, overflow}, 32'd0);
    rx_data = 8'hEE;
    rx_done = 1'b1;
    tick();
    chk("t3_setwins", {31'd0, overflow}, 32'd1);
    rx_done = 1'b0;
    clr_ovf = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) rd("t3_rd", 8'(i));
    chk("t3_empty", {31'd0, empty}, 32'd1);
    chk("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", {31'd0, overflow}, 32'd0);

    // full with simultaneous read and write
    for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i));
    rx_data = 8'h77;
    rx_done = 1'b1;
    rd_en   = 1'b1;
    tick();
    rx_done = 1'b0;
    rd_en   = 1'b0;
    chk("t4_rd", {24'd0, rd_data}, 32'h20);
    chk("t4_count", {27'd0, count}, 32'd16);
    chk("t4_ovf", {31'd0, overflow}, 32'd0);
    tick();
    for (int i = 1; i < 16; i++) rd("t4_drain", 8'h20 + 8'(i));
    rd("t4_last", 8'h77);
    chk("t4_empty", {31'd0, empty}, 32'd1);

    // empty with simultaneous read and write
    rx_data = 8'h11;
    rx_done = 1'b1;
    rd_en   = 1'b1;
    tick();
    rx_done = 1'b0;
    rd_en   = 1'b0;
    chk("t5_rdv", {31'd0, rd_valid}, 32'd0);
    chk("t5_count", {27'd0, count}, 32'd1);
    chk("t5_hold", {24'd0, rd_data}, 32'h77);
    tick();
    rd("t5_rd", 8'h11);

    // rx_done high across reset release
    rx_done = 1'b1;
    reset   = 1'b0;
    tick();
    chk("t6_rst_count", {27'd0, count}, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    chk("t6_nowr", {27'd0, count}, 32'd0);
    rx_done = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      wr(8'h40 + 8'(i));
      rd("t6_wrap", 8'h40 + 8'(i));
    end
    chk("t6_empty", {31'd0, empty}, 32'd1);
    for (int i = 0; i < 5; i++) wr(8'h90 + 8'(i));
    chk("t6_count5", {27'd0, count}, 32'd5);
    reset = 1'b0;
    tick();
    chk("t6_mid_count", {27'd0, count}, 32'd0);
    chk("t6_mid_empty", {31'd0, empty}, 32'd1);
    reset = 1'b1;
    tick();
    wr(8'hC3);
    rd("t6_after", 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
